// File: rtl/frequency_meter.sv
// Gated frequency counter: counts synchronized rising edges of sigIn over
// back-to-back windows of GATE_CYCLES clocks and publishes each window's count.
module frequency_meter #(
    parameter int GATE_CYCLES = 25000000,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             sigIn,
    output logic [CNT_W-1:0] freq,
    output logic             valid,
    output logic             overflow,
    output logic             busy
);

    localparam int               GC_W      = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GC_W-1:0]  GATE_LAST = GC_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic {
        IDLE = 1'b0,
        GATE = 1'b1
    } state_t;

    // Saturating increment; the extra MSB reports that the result was clipped.
    function automatic logic [CNT_W:0] sat_add(input logic [CNT_W-1:0] a, input logic inc);
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + {{CNT_W{1'b0}}, inc};
        if (sum[CNT_W]) begin
            return {1'b1, CNT_MAX};
        end
        return sum;
    endfunction

    logic             sync_p0_q;
    logic             sync_p1_q;
    logic             hist_p2_q;
    logic             edge_det;
    logic [CNT_W:0]   cnt_sum_d;

    state_t           state_q;
    logic [GC_W-1:0]  gate_cnt_q;
    logic [CNT_W-1:0] edge_cnt_q;
    logic             sat_q;
    logic [CNT_W-1:0] freq_q;
    logic             valid_q;
    logic             overflow_q;

    // Stage p0/p1: metastability synchronizer; p2: history flop for edge detect
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_p0_q <= 1'b0;
            sync_p1_q <= 1'b0;
            hist_p2_q <= 1'b0;
        end else begin
            sync_p0_q <= sigIn;
            sync_p1_q <= sync_p0_q;
            hist_p2_q <= sync_p1_q;
        end
    end

    assign edge_det  = sync_p1_q & ~hist_p2_q;
    assign cnt_sum_d = sat_add(edge_cnt_q, edge_det);

    // Gate FSM; the last-cycle edge is folded into the published count so
    // consecutive windows share no edge and lose none.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            gate_cnt_q <= '0;
            edge_cnt_q <= '0;
            sat_q      <= 1'b0;
            freq_q     <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    gate_cnt_q <= '0;
                    edge_cnt_q <= '0;
                    sat_q      <= 1'b0;
                    if (enable) begin
                        state_q <= GATE;
                    end
                end
                GATE: begin
                    if (!enable) begin
                        state_q    <= IDLE;
                        gate_cnt_q <= '0;
                        edge_cnt_q <= '0;
                        sat_q      <= 1'b0;
                    end else if (gate_cnt_q == GATE_LAST) begin
                        freq_q     <= cnt_sum_d[CNT_W-1:0];
                        overflow_q <= sat_q | cnt_sum_d[CNT_W];
                        valid_q    <= 1'b1;
                        gate_cnt_q <= '0;
                        edge_cnt_q <= '0;
                        sat_q      <= 1'b0;
                    end else begin
                        gate_cnt_q <= gate_cnt_q + GC_W'(1);
                        edge_cnt_q <= cnt_sum_d[CNT_W-1:0];
                        sat_q      <= sat_q | cnt_sum_d[CNT_W];
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign freq     = freq_q;
    assign valid    = valid_q;
    assign overflow = overflow_q;
    assign busy     = (state_q == GATE);

endmodule

// File: tb/tb_frequency_meter.sv
// Directed bench for frequency_meter: a 32-bit and a 4-bit instance with
// 100-cycle windows, driven by per-instance square-wave generators.
module tb_frequency_meter;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        sigIn;
    logic [31:0] freq;
    logic        valid;
    logic        overflow;
    logic        busy;

    logic        en4;
    logic        sig4;
    logic [3:0]  freq4;
    logic        valid4;
    logic        overflow4;
    logic        busy4;

    int compared   = 0;
    int mismatched = 0;

    // Generator controls: half > 0 toggles every 'half' negedges, else holds 'hold'.
    int half     = 0;
    bit hold     = 1'b0;
    int injected = 0;
    int half4    = 0;
    bit hold4    = 1'b0;

    always #5 clk = ~clk;

    frequency_meter #(.GATE_CYCLES(100), .CNT_W(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .sigIn    (sigIn),
        .freq     (freq),
        .valid    (valid),
        .overflow (overflow),
        .busy     (busy)
    );

    frequency_meter #(.GATE_CYCLES(100), .CNT_W(4)) dut4 (
        .clk      (clk),
        .reset    (reset),
        .enable   (en4),
        .sigIn    (sig4),
        .freq     (freq4),
        .valid    (valid4),
        .overflow (overflow4),
        .busy     (busy4)
    );

    initial begin
        int ph;
        ph    = 0;
        sigIn = 1'b0;
        forever begin
            @(negedge clk);
            if (half == 0) begin
                ph = 0;
                if (hold && !sigIn) injected++;
                sigIn = hold;
            end else begin
                ph++;
                if (ph >= half) begin
                    ph    = 0;
                    sigIn = ~sigIn;
                    if (sigIn) injected++;
                end
            end
        end
    end

    initial begin
        int ph;
        ph   = 0;
        sig4 = 1'b0;
        forever begin
            @(negedge clk);
            if (half4 == 0) begin
                ph   = 0;
                sig4 = hold4;
            end else begin
                ph++;
                if (ph >= half4) begin
                    ph   = 0;
                    sig4 = ~sig4;
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic wait_valid(input bit which, input int budget, output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        while (n < budget) begin
            @(posedge clk);
            #1;
            n++;
            if ((which ? valid4 : valid) === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        compared++; if (freq !== 32'd0) begin mismatched++; $display("FAIL reset_freq: got %0d want 0", freq); end
        compared++; if (valid !== 1'b0) begin mismatched++; $display("FAIL reset_valid: got %0b want 0", valid); end
        compared++; if (overflow !== 1'b0) begin mismatched++; $display("FAIL reset_overflow: got %0b want 0", overflow); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %0b want 0", busy); end
        compared++; if (freq4 !== 4'd0) begin mismatched++; $display("FAIL reset_freq4: got %0d want 0", freq4); end
        compared++; if (busy4 !== 1'b0) begin mismatched++; $display("FAIL reset_busy4: got %0b want 0", busy4); end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL idle_without_enable: busy got %0b want 0", busy); end
    endtask

    task automatic test_periodic();
        int n;
        bit ok;
        @(negedge clk);
        half   = 5;
        enable = 1'b1;
        @(posedge clk);
        #1;
        compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL busy_on_enable: got %0b want 1", busy); end
        wait_valid(1'b0, 200, n, ok);
        compared++; if (!ok || n !== 100) begin mismatched++; $display("FAIL first_valid_latency: got %0d cycles (seen=%0b) want 100", n, ok); end
        for (int w = 0; w < 3; w++) begin
            wait_valid(1'b0, 200, n, ok);
            compared++;
            if (!ok || n !== 100 || freq !== 32'd10 || overflow !== 1'b0) begin
                mismatched++;
                $display("FAIL periodic_window%0d: got gap=%0d freq=%0d ovf=%0b want gap=100 freq=10 ovf=0", w, n, freq, overflow);
            end
        end
        @(posedge clk);
        #1;
        compared++; if (valid !== 1'b0) begin mismatched++; $display("FAIL valid_one_cycle: got %0b want 0", valid); end
    endtask

    task automatic test_abort();
        int n;
        bit ok;
        int cnt;
        wait_valid(1'b0, 200, n, ok);
        compared++; if (!ok || freq !== 32'd10) begin mismatched++; $display("FAIL abort_pre_freq: got %0d (seen=%0b) want 10", freq, ok); end
        repeat (50) @(posedge clk);
        #1;
        enable = 1'b0;
        @(posedge clk);
        #1;
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL abort_busy: got %0b want 0", busy); end
        cnt = 0;
        repeat (150) begin
            @(posedge clk);
            #1;
            if (valid) cnt++;
        end
        compared++; if (cnt !== 0) begin mismatched++; $display("FAIL abort_no_valid: got %0d pulses want 0", cnt); end
        compared++; if (freq !== 32'd10) begin mismatched++; $display("FAIL abort_freq_hold: got %0d want 10", freq); end
        compared++; if (overflow !== 1'b0) begin mismatched++; $display("FAIL abort_ovf_hold: got %0b want 0", overflow); end
    endtask

    task automatic test_overflow();
        int n;
        bit ok;
        @(negedge clk);
        half4 = 1;
        en4   = 1'b1;
        wait_valid(1'b1, 200, n, ok);
        compared++; if (!ok) begin mismatched++; $display("FAIL ovf_first_valid: got none within 200 cycles want a pulse"); end
        wait_valid(1'b1, 200, n, ok);
        compared++;
        if (!ok || n !== 100 || freq4 !== 4'd15 || overflow4 !== 1'b1) begin
            mismatched++;
            $display("FAIL ovf_saturate: got gap=%0d freq=%0d ovf=%0b want gap=100 freq=15 ovf=1", n, freq4, overflow4);
        end
        half4 = 10;
        wait_valid(1'b1, 200, n, ok);
        wait_valid(1'b1, 200, n, ok);
        compared++;
        if (!ok || n !== 100 || freq4 !== 4'd5 || overflow4 !== 1'b0) begin
            mismatched++;
            $display("FAIL ovf_recover: got gap=%0d freq=%0d ovf=%0b want gap=100 freq=5 ovf=0", n, freq4, overflow4);
        end
        en4   = 1'b0;
        half4 = 0;
        hold4 = 1'b0;
    endtask

    task automatic test_reset_mid();
        int n;
        bit ok;
        @(negedge clk);
        enable = 1'b1;
        wait_valid(1'b0, 200, n, ok);
        compared++; if (!ok || freq !== 32'd10) begin mismatched++; $display("FAIL pre_reset_freq: got %0d (seen=%0b) want 10", freq, ok); end
        repeat (40) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        compared++; if (freq !== 32'd0) begin mismatched++; $display("FAIL midreset_freq: got %0d want 0", freq); end
        compared++; if (valid !== 1'b0) begin mismatched++; $display("FAIL midreset_valid: got %0b want 0", valid); end
        compared++; if (overflow !== 1'b0) begin mismatched++; $display("FAIL midreset_overflow: got %0b want 0", overflow); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL midreset_busy: got %0b want 0", busy); end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL post_reset_gate: busy got %0b want 1", busy); end
        wait_valid(1'b0, 200, n, ok);
        compared++; if (!ok || n !== 100) begin mismatched++; $display("FAIL post_reset_latency: got %0d cycles (seen=%0b) want 100", n, ok); end
    endtask

    task automatic test_constant();
        int n;
        bit ok;
        half = 0;
        hold = 1'b0;
        wait_valid(1'b0, 200, n, ok);
        wait_valid(1'b0, 200, n, ok);
        compared++; if (!ok || freq !== 32'd0 || overflow !== 1'b0) begin mismatched++; $display("FAIL const0_window: got freq=%0d ovf=%0b want 0/0", freq, overflow); end
        hold = 1'b1;
        wait_valid(1'b0, 200, n, ok);
        compared++; if (!ok || freq !== 32'd1) begin mismatched++; $display("FAIL single_rise_window: got %0d want 1", freq); end
        wait_valid(1'b0, 200, n, ok);
        compared++; if (!ok || freq !== 32'd0) begin mismatched++; $display("FAIL const1_window: got %0d want 0", freq); end
        hold = 1'b0;
    endtask

    task automatic test_boundary();
        int n;
        bit ok;
        wait_valid(1'b0, 200, n, ok);
        repeat (97) @(posedge clk);
        hold = 1'b1;
        wait_valid(1'b0, 200, n, ok);
        compared++; if (!ok || n !== 3 || freq !== 32'd1) begin mismatched++; $display("FAIL edge_on_last_cycle: got gap=%0d freq=%0d want gap=3 freq=1", n, freq); end
        hold = 1'b0;
        repeat (98) @(posedge clk);
        hold = 1'b1;
        wait_valid(1'b0, 200, n, ok);
        compared++; if (!ok || n !== 2 || freq !== 32'd0) begin mismatched++; $display("FAIL edge_not_in_early_window: got gap=%0d freq=%0d want gap=2 freq=0", n, freq); end
        wait_valid(1'b0, 200, n, ok);
        compared++; if (!ok || freq !== 32'd1) begin mismatched++; $display("FAIL edge_on_first_cycle: got %0d want 1", freq); end
        hold = 1'b0;
    endtask

    task automatic test_back_to_back();
        int n;
        bit ok;
        bit all_ok;
        int start;
        int sum;
        int bad;
        int pre;
        start  = injected;
        half   = 3;
        sum    = 0;
        bad    = 0;
        pre    = 0;
        all_ok = 1'b1;
        for (int w = 0; w < 10; w++) begin
            wait_valid(1'b0, 200, n, ok);
            if (!ok) all_ok = 1'b0;
            if (n + pre !== 100) bad++;
            pre = 0;
            sum += int'(freq);
            if (w == 8) begin
                repeat (50) @(posedge clk);
                half = 0;
                hold = 1'b0;
                pre  = 50;
            end
        end
        compared++;
        if (!all_ok || sum !== injected - start) begin
            mismatched++;
            $display("FAIL b2b_edge_sum: got %0d (all seen=%0b) want %0d", sum, all_ok, injected - start);
        end
        compared++; if (bad !== 0) begin mismatched++; $display("FAIL b2b_spacing: got %0d irregular gaps want 0", bad); end
    endtask

    initial begin
        reset  = 1'b0;
        enable = 1'b0;
        en4    = 1'b0;
        test_reset();
        test_periodic();
        test_abort();
        test_overflow();
        test_reset_mid();
        test_constant();
        test_boundary();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
